id_pipe_reg: RTL and testbench

- IF→ID pipeline register for the 5-stage MIPS core.
- Accepts a fetched instruction and PC using the valid/allowin handshake, and holds them across stalls.
- Exposes the 16-bit immediate and the one-hot extend control, which feed the immediate sign-extension unit in ID directly.
- Also generates the ID→EX valid and handles pipeline flush.

---
 rtl/id_pipe_reg.sv | 99 +++++++++
 tb/tb_id_pipe_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_reg.sv
// IF->ID pipeline register for the 5-stage MIPS core.
// Captures the fetched instruction/PC under the valid/allowin handshake,
// holds it across load-use stalls and EX back-pressure, kills it on flush,
// and exposes the immediate field plus a one-hot extend select for ID.
//
// state of the ID slot (ds_valid_q) | meaning
//    0                              | empty / bubble, ds_inst don't-care
//    1                              | live instruction waiting to advance
module id_pipe_reg #(
   parameter logic [31:0] PC_RESET = 32'hBFC0_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fs_to_ds_valid,
   input  logic [31:0] fs_inst,
   input  logic [31:0] fs_pc,
   output logic        ds_allowin,
   input  logic        ds_stall,
   input  logic        es_allowin,
   input  logic        flush,
   output logic        ds_valid,
   output logic        ds_to_es_valid,
   output logic [31:0] ds_inst,
   output logic [31:0] ds_pc,
   output logic [15:0] imm,
   output logic [2:0]  extend_con
);

   localparam logic [2:0] EXT_NONE   = 3'b000;
   localparam logic [2:0] EXT_SIGN   = 3'b001;
   localparam logic [2:0] EXT_ZERO   = 3'b010;
   localparam logic [2:0] EXT_BRANCH = 3'b100;

   logic        ds_valid_q, ds_valid_d;
   logic [31:0] ds_inst_q,  ds_inst_d;
   logic [31:0] ds_pc_q,    ds_pc_d;
   logic        ds_ready_go;
   logic [5:0]  op;

   // Handshake: a stall always wins over EX readiness.
   always_comb begin
      ds_ready_go    = !ds_stall;
      ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
      ds_to_es_valid = ds_valid_q && ds_ready_go && !flush;
   end

   // Next-state selection: flush > load/drain > hold.
   always_comb begin
      ds_valid_d = ds_valid_q;
      ds_inst_d  = ds_inst_q;
      ds_pc_d    = ds_pc_q;
      if (flush) begin
         // PC is deliberately kept so a later exception handler can still see it.
         ds_valid_d = 1'b0;
         ds_inst_d  = NOP_INST;
      end else if (ds_allowin) begin
         if (fs_to_ds_valid) begin
            ds_valid_d = 1'b1;
            ds_inst_d  = fs_inst;
            ds_pc_d    = fs_pc;
         end else begin
            ds_valid_d = 1'b0;
         end
      end
   end

   // Pipeline register with synchronous reset overriding everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         ds_valid_q <= 1'b0;
         ds_inst_q  <= NOP_INST;
         ds_pc_q    <= PC_RESET;
      end else begin
         ds_valid_q <= ds_valid_d;
         ds_inst_q  <= ds_inst_d;
         ds_pc_q    <= ds_pc_d;
      end
   end

   // Extend-select decode straight off the register; opcode groups are disjoint.
   always_comb begin
      op         = ds_inst_q[31:26];
      extend_con = EXT_NONE;
      casez (op)
         6'b00100?, 6'b00101?: extend_con = EXT_SIGN;    // ADDI/ADDIU/SLTI/SLTIU
         6'b100???, 6'b101???: extend_con = EXT_SIGN;    // loads / stores
         6'b0011??:            extend_con = EXT_ZERO;    // ANDI/ORI/XORI/LUI
         6'b000001, 6'b0001??: extend_con = EXT_BRANCH;  // REGIMM, BEQ/BNE/BLEZ/BGTZ
         default:              extend_con = EXT_NONE;
      endcase
   end

   assign ds_valid = ds_valid_q;
   assign ds_inst  = ds_inst_q;
   assign ds_pc    = ds_pc_q;
   assign imm      = ds_inst_q[15:0];

endmodule

// File: tb/tb_id_pipe_reg.sv
// Directed + randomized bench for id_pipe_reg against a behavioural model.
module tb_id_pipe_reg;

   localparam logic [31:0] PC_RST = 32'hBFC0_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, fs_to_ds_valid, ds_stall, es_allowin, flush;
   logic [31:0] fs_inst, fs_pc;
   logic        ds_allowin, ds_valid, ds_to_es_valid;
   logic [31:0] ds_inst, ds_pc;
   logic [15:0] imm;
   logic [2:0]  extend_con;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic        m_valid;
   logic [31:0] m_inst, m_pc;

   id_pipe_reg dut (
      .clk(clk), .rst(rst), .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst),
      .fs_pc(fs_pc), .ds_allowin(ds_allowin), .ds_stall(ds_stall),
      .es_allowin(es_allowin), .flush(flush), .ds_valid(ds_valid),
      .ds_to_es_valid(ds_to_es_valid), .ds_inst(ds_inst), .ds_pc(ds_pc),
      .imm(imm), .extend_con(extend_con)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] ref_ext(input logic [31:0] inst);
      int o;
      o = int'(inst[31:26]);
      if ((o >= 8 && o <= 11) || (o >= 32 && o <= 47)) return 3'b001;
      if (o >= 12 && o <= 15)                          return 3'b010;
      if (o == 1 || (o >= 4 && o <= 7))                return 3'b100;
      return 3'b000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic exp_allow;
      exp_allow = !m_valid || (!ds_stall && es_allowin);
      chk("m_allowin", ds_allowin, exp_allow);
      chk("m_to_es", ds_to_es_valid, m_valid && !ds_stall && !flush);
      chk("m_valid", ds_valid, m_valid);
      chk("m_inst", ds_inst, m_inst);
      chk("m_pc", ds_pc, m_pc);
      chk("m_imm", imm, m_inst[15:0]);
      chk("m_ext", extend_con, ref_ext(m_inst));
      chk("m_onehot", $countones(extend_con) <= 1, 1'b1);
   endtask

   task automatic model_update();
      logic allow;
      allow = !m_valid || (!ds_stall && es_allowin);
      if (rst) begin
         m_valid = 1'b0; m_inst = NOP; m_pc = PC_RST;
      end else if (flush) begin
         m_valid = 1'b0; m_inst = NOP;
      end else if (allow) begin
         if (fs_to_ds_valid) begin
            m_valid = 1'b1; m_inst = fs_inst; m_pc = fs_pc;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   // check at negedge, advance model at posedge, settle inputs/outputs 1ns after
   task automatic tick();
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_update();
      #1;
   endtask

   localparam logic [5:0] OPS [12] = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h07, 6'h08,
                                        6'h0B, 6'h0C, 6'h0F, 6'h10, 6'h23, 6'h2B};

   initial begin
      rst = 1'b1; fs_to_ds_valid = 1'b0; ds_stall = 1'b0; es_allowin = 1'b0;
      flush = 1'b0; fs_inst = 32'h0; fs_pc = 32'h0;
      @(posedge clk);
      m_valid = 1'b0; m_inst = NOP; m_pc = PC_RST;
      #1;
      tick();
      chk("rst_valid", ds_valid, 1'b0);
      chk("rst_inst", ds_inst, NOP);
      chk("rst_pc", ds_pc, PC_RST);
      chk("rst_ext", extend_con, 3'b000);

      // ADDIU load
      rst = 1'b0; fs_to_ds_valid = 1'b1; fs_inst = 32'h2408FFFC;
      fs_pc = 32'hBFC00000; es_allowin = 1'b1;
      tick();
      chk("addiu_valid", ds_valid, 1'b1);
      chk("addiu_imm", imm, 16'hFFFC);
      chk("addiu_ext", extend_con, 3'b001);
      chk("addiu_to_es", ds_to_es_valid, 1'b1);

      // back-to-back ORI, BEQ
      fs_inst = 32'h3508FFFF; fs_pc = 32'hBFC00004;
      tick();
      chk("ori_ext", extend_con, 3'b010);
      chk("ori_imm", imm, 16'hFFFF);
      fs_inst = 32'h11000003; fs_pc = 32'hBFC00008;
      tick();
      chk("beq_ext", extend_con, 3'b100);
      chk("beq_imm", imm, 16'h0003);
      chk("beq_valid", ds_valid, 1'b1);

      // LW held by a 3-cycle stall while ADDU waits in IF
      fs_inst = 32'h8D090004; fs_pc = 32'hBFC0000C;
      tick();
      ds_stall = 1'b1; fs_inst = 32'h01095021; fs_pc = 32'hBFC00010;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_allowin", ds_allowin, 1'b0);
         chk("stall_to_es", ds_to_es_valid, 1'b0);
         chk("stall_inst", ds_inst, 32'h8D090004);
      end
      ds_stall = 1'b0;
      tick();
      chk("addu_inst", ds_inst, 32'h01095021);
      chk("addu_ext", extend_con, 3'b000);

      // EX back-pressure with IF churning
      es_allowin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fs_inst = $urandom; fs_pc = $urandom;
         tick();
         chk("bp_inst", ds_inst, 32'h01095021);
         chk("bp_pc", ds_pc, 32'hBFC00010);
      end
      es_allowin = 1'b1;

      // flush beats a simultaneous load
      flush = 1'b1; fs_inst = 32'h2408FFFC; fs_pc = 32'hBFC00020;
      tick();
      flush = 1'b0; fs_to_ds_valid = 1'b0;
      chk("flush_valid", ds_valid, 1'b0);
      chk("flush_inst", ds_inst, 32'h00000000);
      chk("flush_ext", extend_con, 3'b000);
      chk("flush_to_es", ds_to_es_valid, 1'b0);
      chk("flush_pc", ds_pc, 32'hBFC00010);

      // reset mid-stall
      fs_to_ds_valid = 1'b1; fs_inst = 32'h8D090004; fs_pc = 32'hBFC00030;
      tick();
      ds_stall = 1'b1; rst = 1'b1;
      tick();
      chk("rstmid_valid", ds_valid, 1'b0);
      chk("rstmid_pc", ds_pc, PC_RST);
      chk("rstmid_inst", ds_inst, NOP);
      rst = 1'b0; ds_stall = 1'b0; fs_inst = 32'h3508FFFF; fs_pc = 32'hBFC00040;
      tick();
      chk("after_rst_inst", ds_inst, 32'h3508FFFF);
      chk("after_rst_valid", ds_valid, 1'b1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(0, 99) < 2);
         flush          = ($urandom_range(0, 99) < 6);
         ds_stall       = ($urandom_range(0, 99) < 25);
         es_allowin     = ($urandom_range(0, 99) < 70);
         fs_to_ds_valid = ($urandom_range(0, 99) < 70);
         fs_inst        = $urandom;
         if ($urandom_range(0, 1) == 1)
            fs_inst[31:26] = OPS[$urandom_range(0, 11)];
         fs_pc          = $urandom;
         tick();
      end
      rst = 1'b0; flush = 1'b0; ds_stall = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
